// File: rtl/inseq_pkg.sv
// Shared unit codes, issue-state encoding and the unit rotation helper
// for the input sequencer.
package inseq_pkg;

    localparam logic [1:0] UNIT_ARITH = 2'd0;
    localparam logic [1:0] UNIT_LOGIC = 2'd1;
    localparam logic [1:0] UNIT_COMP  = 2'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } issue_state_t;

    // ARITH -> LOGIC -> COMP -> ARITH; code 3 folds back to ARITH.
    function automatic logic [1:0] next_unit(input logic [1:0] unit);
        case (unit)
            UNIT_ARITH: next_unit = UNIT_LOGIC;
            UNIT_LOGIC: next_unit = UNIT_COMP;
            default:    next_unit = UNIT_ARITH;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button front end: 2-flop synchronizer, debouncer holding the
// accepted level, and a registered one-cycle pulse on each accepted press
// (stable 1->0). Releases produce no pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          level_d;

    // Two-stage synchronizer; idles high so reset looks like "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], key_n};
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync_q[1] == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered press pulse, one cycle after the stable level falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b1;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level_d & ~level;
        end
    end

endmodule

// File: rtl/input_sequencer.sv
// Front end for the mini-CPU datapath: debounced keys, unit selection,
// operand capture and a single-entry valid/ready offer to the ALU stage.
// Optional build macro: INSEQ_AUTO_REPEAT_EN adds hold-to-repeat on KEY1.
//
// Issue FSM
//   state    | meaning
//   ST_IDLE  | nothing offered; KEY1 press captures sw and cur_unit
//   ST_ISSUE | op_valid=1, fields frozen until op_ready on a clock edge
module input_sequencer
    import inseq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_n,
    input  logic [9:0] sw,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [1:0] op,
    output logic [1:0] unit_sel,
    output logic [1:0] cur_unit,
    output logic       op_valid,
    input  logic       op_ready
);

    logic [1:0]   level;
    logic [1:0]   press;
    logic         repeat_evt;
    logic         issue_evt;
    issue_state_t state;

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .clk   (clk),
            .rst_n (rst_n),
            .key_n (key_n[k]),
            .level (level[k]),
            .press (press[k])
        );
    end

`ifdef INSEQ_AUTO_REPEAT_EN
    localparam int HW = (REPEAT_CYCLES < 2) ? 1 : $clog2(REPEAT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] hold_cnt;
    logic          unused_level;
    assign unused_level = level[0];

    // While KEY1 is stably held, emit a synthetic press every REPEAT_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            repeat_evt <= 1'b0;
        end else if (level[1]) begin
            hold_cnt   <= '0;
            repeat_evt <= 1'b0;
        end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt   <= '0;
            repeat_evt <= 1'b1;
        end else begin
            hold_cnt   <= hold_cnt + 1'b1;
            repeat_evt <= 1'b0;
        end
    end
`else
    localparam int unused_repeat_cycles = REPEAT_CYCLES;
    logic [1:0] unused_level;
    assign unused_level = level;
    assign repeat_evt   = 1'b0;
`endif

    assign issue_evt = press[1] | repeat_evt;

    // Unit rotation, issue FSM and capture registers with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_valid <= 1'b0;
            cur_unit <= UNIT_ARITH;
            unit_sel <= UNIT_ARITH;
            op       <= 2'd0;
            x        <= 4'd0;
            y        <= 4'd0;
        end else begin
            if (press[0]) cur_unit <= next_unit(cur_unit);
            case (state)
                ST_IDLE: begin
                    if (issue_evt) begin
                        // cur_unit here is the pre-advance value on a shared edge.
                        op       <= sw[9:8];
                        x        <= sw[7:4];
                        y        <= sw[3:0];
                        unit_sel <= cur_unit;
                        op_valid <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    op_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_sequencer.sv
// Scoreboard bench for input_sequencer with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16.
module tb_input_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key_n = 2'b11;
    logic [9:0] sw = 10'd0;
    logic       op_ready = 1'b0;
    logic [3:0] x, y;
    logic [1:0] op, unit_sel, cur_unit;
    logic       op_valid;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] unit;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur_exp;
    bit   in_txn = 1'b0;
    bit   unexp  = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   txn_count = 0;
    int   base_cnt;
    int   n_expected;

    input_sequencer #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .sw       (sw),
        .x        (x),
        .y        (y),
        .op       (op),
        .unit_sel (unit_sel),
        .cur_unit (cur_unit),
        .op_valid (op_valid),
        .op_ready (op_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx, input int hold);
        key_n[idx] = 1'b0;
        tick(hold);
        key_n[idx] = 1'b1;
        tick(12);
    endtask

    task automatic accept();
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        check("valid_drop_after_ready", int'(op_valid), 0);
    endtask

    task automatic push(input logic [1:0] o, input logic [3:0] xv,
                        input logic [3:0] yv, input logic [1:0] u);
        txn_t t;
        t.op = o; t.x = xv; t.y = yv; t.unit = u;
        exp_q.push_back(t);
    endtask

    // Monitor: pop one expectation per offered transaction, verify fields every valid cycle.
    always @(negedge clk) begin
        if (rst_n && op_valid) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                txn_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    unexp = 1'b1;
                    $display("FAIL unexpected_txn actual=op%0d x%0d y%0d required=none", op, x, y);
                end else begin
                    unexp = 1'b0;
                    cur_exp = exp_q.pop_front();
                end
            end
            if (!unexp) begin
                check("sb_op", int'(op), int'(cur_exp.op));
                check("sb_x", int'(x), int'(cur_exp.x));
                check("sb_y", int'(y), int'(cur_exp.y));
                check("sb_unit_sel", int'(unit_sel), int'(cur_exp.unit));
            end
        end else begin
            in_txn = 1'b0;
        end
    end

    initial begin
        // Reset values
        tick(3);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_op", int'(op), 0);
        check("rst_unit_sel", int'(unit_sel), 0);
        check("rst_cur_unit", int'(cur_unit), 0);
        check("rst_op_valid", int'(op_valid), 0);
        rst_n = 1'b1;
        tick(2);

        // Latency: op_valid rises exactly at edge 7 after KEY1 goes low
        sw = 10'b10_0110_0011;
        push(2'd2, 4'd6, 4'd3, 2'd0);
        key_n[1] = 1'b0;
        tick(7);
        check("lat_edge6_valid", int'(op_valid), 0);
        tick(1);
        check("lat_edge7_valid", int'(op_valid), 1);
        check("lat_op", int'(op), 2);
        check("lat_x", int'(x), 6);
        check("lat_y", int'(y), 3);
        key_n[1] = 1'b1;
        tick(20);
        check("hold_valid_20", int'(op_valid), 1);
        accept();

        // Unit rotation and a sub-threshold glitch
        press(0, 8);
        check("unit_1", int'(cur_unit), 1);
        press(0, 8);
        check("unit_2", int'(cur_unit), 2);
        press(0, 8);
        check("unit_wrap_0", int'(cur_unit), 0);
        key_n[0] = 1'b0;
        tick(3);
        key_n[0] = 1'b1;
        tick(12);
        check("glitch_no_advance", int'(cur_unit), 0);

        // KEY1 press while ISSUE is dropped
        sw = 10'b01_1010_0101;
        push(2'd1, 4'd10, 4'd5, 2'd0);
        press(1, 8);
        check("issue_a_valid", int'(op_valid), 1);
        sw = 10'h3FF;
        press(1, 8);
        check("drop_valid", int'(op_valid), 1);
        check("drop_x_frozen", int'(x), 10);
        check("drop_op_frozen", int'(op), 1);
        accept();
        push(2'd3, 4'd15, 4'd15, 2'd0);
        press(1, 8);
        check("issue_b_x", int'(x), 15);
        accept();

        // Simultaneous KEY0/KEY1: capture pre-advance unit, advance same edge
        press(0, 8);
        check("unit_pre_both", int'(cur_unit), 1);
        sw = 10'b00_0001_0010;
        push(2'd0, 4'd1, 4'd2, 2'd1);
        key_n = 2'b00;
        tick(7);
        check("both_edge6_unit", int'(cur_unit), 1);
        check("both_edge6_valid", int'(op_valid), 0);
        tick(1);
        check("both_edge7_unit", int'(cur_unit), 2);
        check("both_edge7_valid", int'(op_valid), 1);
        check("both_unit_sel", int'(unit_sel), 1);
        key_n = 2'b11;
        tick(12);
        accept();

        // Asynchronous reset mid-ISSUE
        sw = 10'b11_0101_1010;
        push(2'd3, 4'd5, 4'd10, 2'd2);
        press(1, 8);
        check("pre_reset_valid", int'(op_valid), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(op_valid), 0);
        check("arst_x", int'(x), 0);
        check("arst_y", int'(y), 0);
        check("arst_op", int'(op), 0);
        check("arst_unit_sel", int'(unit_sel), 0);
        check("arst_cur_unit", int'(cur_unit), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Long hold of KEY1 with op_ready=1
        sw = 10'b01_0011_1100;
        op_ready = 1'b1;
        base_cnt = txn_count;
`ifdef INSEQ_AUTO_REPEAT_EN
        n_expected = 4;
`else
        n_expected = 1;
`endif
        for (int i = 0; i < n_expected; i++) push(2'd1, 4'd3, 4'd12, 2'd0);
        key_n[1] = 1'b0;
        tick(60);
        key_n[1] = 1'b1;
        tick(20);
        op_ready = 1'b0;
        check("hold_issue_count", txn_count - base_cnt, n_expected);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
